// File: rtl/timer_defs.sv
// ============================================================================
//  Module      : timer_defs (package)
//  Description : Shared definitions for the multi-channel DIV/TIMA/TMA/TAC
//                timer: register offsets, TAC tap-bit positions and the
//                channel overflow/reload state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_defs;

    // Register offsets within a channel window (iAddr[1:0])
    localparam logic [1:0] REG_DIV  = 2'd0;
    localparam logic [1:0] REG_TIMA = 2'd1;
    localparam logic [1:0] REG_TMA  = 2'd2;
    localparam logic [1:0] REG_TAC  = 2'd3;

    // System-counter bit observed for each TAC[1:0] selection
    localparam int TAP_BIT_SEL0 = 9;
    localparam int TAP_BIT_SEL1 = 3;
    localparam int TAP_BIT_SEL2 = 5;
    localparam int TAP_BIT_SEL3 = 7;

    // Address space always decodes four channel windows
    localparam int MAX_CH = 4;

    // Channel overflow sequencing
    typedef enum logic [1:0] {
        CH_RUN    = 2'd0,
        CH_OVF    = 2'd1,
        CH_RELOAD = 2'd2
    } ch_state_e;

    // TAC bits [7:3] are not stored and always read back as ones
    function automatic logic [7:0] tac_readback(input logic [2:0] tac);
        return {5'b11111, tac};
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// ============================================================================
//  Module      : timer_channel
//  Description : One TIMA/TMA/TAC timer channel. Detects falling edges of
//                (selected counter tap & enable) between the current and the
//                next-cycle state, handles the delayed overflow reload and
//                emits a one-cycle interrupt pulse.
//  Ports       : iClock/iReset  - clock, synchronous active-high reset
//                iTick          - M-cycle pulse
//                iCurTaps       - counter tap bits now   {sel3,sel2,sel1,sel0}
//                iNxtTaps       - counter tap bits after this edge
//                iWrTima/iWrTma/iWrTac - decoded write strobes, iWData data
//                oTima/oTma/oTac - stored register values
//                oIrq           - interrupt pulse, coincident with the reload
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_channel
    import timer_defs::*;
(
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iTick,
    input  logic [3:0] iCurTaps,
    input  logic [3:0] iNxtTaps,
    input  logic       iWrTima,
    input  logic       iWrTma,
    input  logic       iWrTac,
    input  logic [7:0] iWData,
    output logic [7:0] oTima,
    output logic [7:0] oTma,
    output logic [2:0] oTac,
    output logic       oIrq
);

    ch_state_e  state_q, state_d;
    logic [7:0] tima_q, tima_d;
    logic [7:0] tma_q, tma_d;
    logic [2:0] tac_q, tac_d;
    logic       irq_q, irq_d;
    logic       inc_cur, inc_nxt, fall;
    logic [7:0] base;

    assign tma_d = iWrTma ? iWData : tma_q;
    assign tac_d = iWrTac ? iWData[2:0] : tac_q;

    // The "next" side uses the post-write TAC, so disabling the channel or
    // moving the tap while the old tap is high produces an increment, as on
    // the original part.
    assign inc_cur = iCurTaps[tac_q[1:0]] & tac_q[2];
    assign inc_nxt = iNxtTaps[tac_d[1:0]] & tac_d[2];
    assign fall    = inc_cur & ~inc_nxt;

    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        irq_d   = 1'b0;
        base    = tima_q;
        unique case (state_q)
            CH_RUN: begin
                if (iWrTima) begin
                    tima_d = iWData;
                end else if (fall) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = CH_OVF;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            CH_OVF: begin
                // TIMA sits at zero for one M-cycle before the reload
                if (iWrTima) begin
                    tima_d  = iWData;
                    state_d = CH_RUN;
                end else if (iTick) begin
                    tima_d  = tma_d;
                    irq_d   = 1'b1;
                    state_d = CH_RELOAD;
                end
            end
            CH_RELOAD: begin
                // TIMA writes are dropped; TMA writes pass through to TIMA
                base   = iWrTma ? iWData : tima_q;
                tima_d = base;
                if (iTick) begin
                    state_d = CH_RUN;
                end
                if (fall) begin
                    if (base == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = CH_OVF;
                    end else begin
                        tima_d = base + 8'd1;
                    end
                end
            end
            default: state_d = CH_RUN;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= CH_RUN;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            irq_q   <= irq_d;
        end
    end

    assign oTima = tima_q;
    assign oTma  = tma_q;
    assign oTac  = tac_q;
    assign oIrq  = irq_q;

endmodule

`default_nettype wire

// File: rtl/timer_unit.sv
// ============================================================================
//  Module      : timer_unit
//  Description : Multi-channel DIV/TIMA/TMA/TAC timer. Holds the shared
//                free-running system counter, the register address decode and
//                the read mux; one timer_channel per channel.
//  Ports       : iClock/iReset - clock, synchronous active-high reset
//                iTick         - M-cycle pulse gating all timer progress
//                iWe/iAddr/iWData - register write {ch[1:0],reg[1:0]}
//                oRData        - combinational read data for iAddr
//                oDiv          - upper byte of the system counter
//                oTima         - TIMA of every channel, ch0 in [7:0]
//                oIrq          - per-channel interrupt pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_unit
    import timer_defs::*;
#(
    parameter int N_CH     = 1,
    parameter int CNT_W    = 16,
    parameter int TICK_INC = 4,
    parameter int CNT_INIT = 0
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iTick,
    input  logic              iWe,
    input  logic [3:0]        iAddr,
    input  logic [7:0]        iWData,
    output logic [7:0]        oRData,
    output logic [7:0]        oDiv,
    output logic [8*N_CH-1:0] oTima,
    output logic [N_CH-1:0]   oIrq
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_ch, addr_reg;
    logic             ch_valid, wr_any, div_wr;
    logic [3:0]       cur_taps, nxt_taps;

    // Padded to the full address space so the read mux indexes cleanly
    logic [7:0] tima_all [MAX_CH];
    logic [7:0] tma_all  [MAX_CH];
    logic [2:0] tac_all  [MAX_CH];

    assign addr_ch  = iAddr[3:2];
    assign addr_reg = iAddr[1:0];
    assign ch_valid = int'(addr_ch) < N_CH;
    assign wr_any   = iWe & ch_valid;
    assign div_wr   = wr_any & (addr_reg == REG_DIV);

    // DIV write clears the counter and wins over a same-cycle tick
    always_comb begin
        cnt_d = cnt_q;
        if (div_wr) begin
            cnt_d = '0;
        end else if (iTick) begin
            cnt_d = cnt_q + CNT_W'(TICK_INC);
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            cnt_q <= CNT_W'(CNT_INIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oDiv = cnt_q[CNT_W-1 -: 8];

    assign cur_taps = {cnt_q[TAP_BIT_SEL3], cnt_q[TAP_BIT_SEL2],
                       cnt_q[TAP_BIT_SEL1], cnt_q[TAP_BIT_SEL0]};
    assign nxt_taps = {cnt_d[TAP_BIT_SEL3], cnt_d[TAP_BIT_SEL2],
                       cnt_d[TAP_BIT_SEL1], cnt_d[TAP_BIT_SEL0]};

    generate
        for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
            if (i < N_CH) begin : g_used
                logic sel;
                assign sel = wr_any & (addr_ch == 2'(i));

                timer_channel u_channel (
                    .iClock   (iClock),
                    .iReset   (iReset),
                    .iTick    (iTick),
                    .iCurTaps (cur_taps),
                    .iNxtTaps (nxt_taps),
                    .iWrTima  (sel & (addr_reg == REG_TIMA)),
                    .iWrTma   (sel & (addr_reg == REG_TMA)),
                    .iWrTac   (sel & (addr_reg == REG_TAC)),
                    .iWData   (iWData),
                    .oTima    (tima_all[i]),
                    .oTma     (tma_all[i]),
                    .oTac     (tac_all[i]),
                    .oIrq     (oIrq[i])
                );

                assign oTima[8*i +: 8] = tima_all[i];
            end else begin : g_absent
                assign tima_all[i] = 8'hFF;
                assign tma_all[i]  = 8'hFF;
                assign tac_all[i]  = 3'b111;
            end
        end
    endgenerate

    always_comb begin
        oRData = 8'hFF;
        if (ch_valid) begin
            case (addr_reg)
                REG_DIV:  oRData = oDiv;
                REG_TIMA: oRData = tima_all[addr_ch];
                REG_TMA:  oRData = tma_all[addr_ch];
                REG_TAC:  oRData = tac_readback(tac_all[addr_ch]);
            endcase
        end
    end

    // Counter bits that are neither DIV nor a tap are intentionally unread
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_unit.sv
// ============================================================================
//  Module      : tb_timer_unit
//  Description : Self-checking bench for timer_unit (two channels): directed
//                scenarios plus random register traffic, checked every cycle
//                against a behavioural model of the timer rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_unit;

    localparam int N_CH = 2;

    logic              iClock = 1'b0;
    logic              iReset;
    logic              iTick;
    logic              iWe;
    logic [3:0]        iAddr;
    logic [7:0]        iWData;
    logic [7:0]        oRData;
    logic [7:0]        oDiv;
    logic [8*N_CH-1:0] oTima;
    logic [N_CH-1:0]   oIrq;

    always #5 iClock = ~iClock;

    timer_unit #(
        .N_CH     (N_CH),
        .CNT_W    (16),
        .TICK_INC (4),
        .CNT_INIT (0)
    ) dut (
        .iClock (iClock),
        .iReset (iReset),
        .iTick  (iTick),
        .iWe    (iWe),
        .iAddr  (iAddr),
        .iWData (iWData),
        .oRData (oRData),
        .oDiv   (oDiv),
        .oTima  (oTima),
        .oIrq   (oIrq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. m_wait: 0 = counting, 1 = overflowed and waiting
    // for the reload tick, 2 = inside the M-cycle following the reload.
    // ------------------------------------------------------------------
    int m_cnt;
    int m_tima [N_CH];
    int m_tma  [N_CH];
    int m_tac  [N_CH];
    int m_wait [N_CH];
    int m_irq  [N_CH];

    function automatic bit inc_level(input int cnt, input int tac);
        int b;
        case (tac & 3)
            0:       b = 9;
            1:       b = 3;
            2:       b = 5;
            default: b = 7;
        endcase
        return (((cnt >> b) & 1) == 1) && ((tac & 4) != 0);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_tima[c] = 0; m_tma[c] = 0; m_tac[c] = 0; m_wait[c] = 0; m_irq[c] = 0;
        end
    endtask

    function automatic int exp_read(input logic [3:0] addr);
        int ch, rg;
        ch = int'(addr[3:2]);
        rg = int'(addr[1:0]);
        if (ch >= N_CH) return 255;
        case (rg)
            0:       return (m_cnt >> 8) & 255;
            1:       return m_tima[ch];
            2:       return m_tma[ch];
            default: return 248 | m_tac[ch];
        endcase
    endfunction

    task automatic model_step(input bit tick, input bit we, input logic [3:0] addr, input logic [7:0] wd);
        int  ch, rg, n_cnt;
        bit  wv;
        ch = int'(addr[3:2]);
        rg = int'(addr[1:0]);
        wv = we && (ch < N_CH);
        if (wv && rg == 0)  n_cnt = 0;
        else if (tick)      n_cnt = (m_cnt + 4) % 65536;
        else                n_cnt = m_cnt;
        for (int c = 0; c < N_CH; c++) begin
            bit wt, wm, wc, fall;
            int n_tac, n_tma, base;
            wt    = wv && ch == c && rg == 1;
            wm    = wv && ch == c && rg == 2;
            wc    = wv && ch == c && rg == 3;
            n_tac = wc ? int'(wd) & 7 : m_tac[c];
            n_tma = wm ? int'(wd) : m_tma[c];
            fall  = inc_level(m_cnt, m_tac[c]) && !inc_level(n_cnt, n_tac);
            m_irq[c] = 0;
            if (m_wait[c] == 1) begin
                if (wt) begin
                    m_tima[c] = int'(wd);
                    m_wait[c] = 0;
                end else if (tick) begin
                    m_tima[c] = n_tma;
                    m_irq[c]  = 1;
                    m_wait[c] = 2;
                end
            end else if (m_wait[c] == 0 && wt) begin
                m_tima[c] = int'(wd);
            end else begin
                base = (m_wait[c] == 2 && wm) ? int'(wd) : m_tima[c];
                if (m_wait[c] == 2 && tick) m_wait[c] = 0;
                if (fall) begin
                    if (base == 255) begin
                        base      = 0;
                        m_wait[c] = 1;
                    end else begin
                        base = base + 1;
                    end
                end
                m_tima[c] = base;
            end
            m_tma[c] = n_tma;
            m_tac[c] = n_tac;
        end
        m_cnt = n_cnt;
    endtask

    task automatic check_outputs();
        chk("div", 32'(oDiv), 32'((m_cnt >> 8) & 255));
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("tima%0d", c), 32'(oTima[8*c +: 8]), 32'(m_tima[c]));
            chk($sformatf("irq%0d", c),  32'(oIrq[c]),         32'(m_irq[c]));
        end
    endtask

    // One clock: inputs applied just after a rising edge, read data checked
    // on the falling edge, registered outputs checked 1 ns after the next edge.
    task automatic do_cycle(input bit tick, input bit we, input logic [3:0] addr, input logic [7:0] wd);
        iTick  = tick;
        iWe    = we;
        iAddr  = addr;
        iWData = wd;
        @(negedge iClock);
        chk("rdata", 32'(oRData), 32'(exp_read(addr)));
        model_step(tick, we, addr, wd);
        @(posedge iClock);
        #1;
        iTick = 1'b0;
        iWe   = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        iTick  = 1'b0;
        iWe    = 1'b0;
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        model_reset();
        check_outputs();
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        do_cycle(1'b0, 1'b1, addr, data);
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 4'h0, 8'h00);
    endtask

    // Ticks until channel 0 TIMA reaches zero, bounded
    task automatic tick_to_overflow(input string tag);
        int k;
        k = 0;
        while (oTima[7:0] !== 8'h00 && k < 16) begin
            tk(1);
            k++;
        end
        chk(tag, 32'(oTima[7:0]), 32'h00);
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rd;
        bit         rt, rw;
        int         irq_seen;

        iReset = 1'b1; iTick = 1'b0; iWe = 1'b0; iAddr = 4'h0; iWData = 8'h00;
        @(posedge iClock);
        #1;
        do_reset();
        chk("rst_div",  32'(oDiv),  32'h00);
        chk("rst_tima", 32'(oTima), 32'h0000);
        chk("rst_irq",  32'(oIrq),  32'h0);

        // Channel 0 on bit 3: one increment every 4 ticks
        wr(4'h3, 8'h05);
        tk(4);
        chk("t1_tima_after4", 32'(oTima[7:0]), 32'd1);
        tk(4);
        chk("t1_tima_after8", 32'(oTima[7:0]), 32'd2);
        chk("t1_irq", 32'(oIrq), 32'h0);

        // Overflow then reload from TMA with a one-cycle interrupt
        do_reset();
        wr(4'h2, 8'hAB);
        wr(4'h1, 8'hFF);
        wr(4'h3, 8'h05);
        tick_to_overflow("t2_tima_ovf");
        chk("t2_irq_at_ovf", 32'(oIrq[0]), 32'h0);
        tk(1);
        chk("t2_tima_reload", 32'(oTima[7:0]), 32'hAB);
        chk("t2_irq_pulse",   32'(oIrq[0]),    32'h1);
        do_cycle(1'b0, 1'b0, 4'h1, 8'h00);
        chk("t2_irq_drop",  32'(oIrq[0]),    32'h0);
        chk("t2_tima_hold", 32'(oTima[7:0]), 32'hAB);

        // TIMA write during OVF cancels reload and interrupt
        do_reset();
        wr(4'h2, 8'hAB);
        wr(4'h1, 8'hFF);
        wr(4'h3, 8'h05);
        tick_to_overflow("t3_tima_ovf");
        wr(4'h1, 8'h10);
        chk("t3_tima_written", 32'(oTima[7:0]), 32'h10);
        irq_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tk(1);
            irq_seen = irq_seen | int'(oIrq[0]);
        end
        chk("t3_no_irq", 32'(irq_seen), 32'h0);
        chk("t3_tima_counted", 32'(oTima[7:0]), 32'h12);

        // DIV write with the bit-9 tap high gives a spurious increment
        do_reset();
        wr(4'h3, 8'h04);
        tk(128);
        chk("t4_tima_before", 32'(oTima[7:0]), 32'h00);
        chk("t4_div_before",  32'(oDiv),       32'h02);
        wr(4'h0, 8'h5A);
        chk("t4_tima_spurious", 32'(oTima[7:0]), 32'h01);
        chk("t4_div_cleared",   32'(oDiv),       32'h00);

        // Disabling the channel while the tap is high increments TIMA
        do_reset();
        wr(4'h3, 8'h05);
        tk(2);
        chk("t5_tima_before", 32'(oTima[7:0]), 32'h00);
        wr(4'h3, 8'h01);
        chk("t5_tima_disable", 32'(oTima[7:0]), 32'h01);

        // Channel 1 on bit 7, channel 0 disabled
        do_reset();
        wr(4'h7, 8'h07);
        tk(192);
        chk("t6_ch1_tima", 32'(oTima[15:8]), 32'h03);
        chk("t6_ch0_tima", 32'(oTima[7:0]),  32'h00);
        do_cycle(1'b0, 1'b0, 4'h9, 8'h00);
        chk("t6_read_oob", 32'(oRData), 32'hFF);
        do_cycle(1'b0, 1'b0, 4'h3, 8'h00);
        chk("t6_read_tac0", 32'(oRData), 32'hF8);
        wr(4'hA, 8'h33);
        chk("t6_oob_write", 32'(oTima), 32'h0300);

        // Random register traffic, biased towards overflows
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rt = ($urandom_range(0, 1) == 1);
                rw = ($urandom_range(0, 4) == 0);
                ra = 4'($urandom_range(0, 15));
                if (rw && ra[1:0] == 2'd0 && $urandom_range(0, 3) != 0)
                    ra[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 2) == 0)
                    rd = 8'hFC | 8'($urandom_range(0, 3));
                else
                    rd = 8'($urandom);
                do_cycle(rt, rw, ra, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_unit.md
# timer_unit

Parametrised multi-channel successor to the single-channel DIV/TIMA/TMA/TAC timer, driven by a per-M-cycle tick from the CPU core. It has:

- one shared free-running system counter, with DIV as its upper byte;
- N independent TIMA/TMA/TAC channels, each with hardware-accurate falling-edge increment detection, a delayed overflow reload and a one-cycle interrupt pulse.

It sits on the MCU register bus beside the interrupt controller. Channel 0 maps to 0xFF04–0xFF07.

## Interface
Parameters:
- N_CH, 1: number of timer channels (1–4).
- CNT_W, 16: system counter width (≥10); DIV = counter[CNT_W-1:CNT_W-8].
- TICK_INC, 4: counter increment per iTick (T-cycles per M-cycle).
- CNT_INIT, 0: system counter value after reset.

Ports:
- iClock  in  1  clock.
- iReset  in  1  reset; synchronous, active-high.
- iTick  in  1  one-cycle pulse per M-cycle; all timer progress is gated by it.
- iWe  in  1  register write strobe, one cycle.
- iAddr  in  4  {channel[1:0], reg[1:0]}; reg 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- iWData  in  8  write data.
- oRData  out  8  combinational read data for iAddr.
- oDiv  out  8  DIV, shared.
- oTima  out  8*N_CH  TIMA per channel, channel 0 in bits [7:0].
- oIrq  out  N_CH  per-channel timer interrupt, one-cycle pulse.

## Operation
- System counter:
  - On iTick, cnt <= cnt + TICK_INC, wrapping modulo 2^CNT_W.
  - A write to DIV on any channel address sets cnt <= 0. This overrides an increment in the same cycle.
- TAC bits:
  - [1:0] select the tap bit: 00→bit 9, 01→bit 3, 10→bit 5, 11→bit 7.
  - [2] enables the channel.
  - [7:3] are not stored and read back as 1.
- Increment signal: inc_sig = cnt[tap] & TAC[2].
  - Compare inc_sig computed from the current state with inc_sig computed from the next-cycle state (after tick, DIV write and TAC write).
  - A 1→0 transition increments TIMA.
  - This intentionally reproduces the DIV-write and TAC-change spurious increments.
- Channel FSM:
  - RUN: an increment with TIMA=0xFF sets TIMA <= 0x00 and goes to OVF.
  - OVF: TIMA holds 0x00. On the next iTick: TIMA <= TMA, pulse oIrq for that cycle, go to RELOAD.
  - RELOAD: lasts until the next iTick, then returns to RUN. Increments detected in RELOAD apply to the reloaded value.
- Write rules:
  - TIMA write in RUN: loads iWData; a same-cycle increment is discarded.
  - TIMA write in OVF: loads iWData, cancels the reload and the interrupt, returns to RUN.
  - TIMA write in RELOAD: ignored.
  - TMA write in RELOAD: also updates TIMA to iWData.
- Reads:
  - DIV returns oDiv on any channel address.
  - TIMA and TMA return the stored value.
  - TAC returns {5'b11111, tac[2:0]}.
  - An address whose channel ≥ N_CH reads 0xFF; writes to it are ignored.

## Timing
- Reset values:
  - cnt = CNT_INIT.
  - Per channel: TIMA=0, TMA=0, TAC=0, state RUN.
  - oIrq=0, so oDiv reflects CNT_INIT.
- Latency:
  - A write is visible on oRData the cycle after the iWe edge.
  - TIMA updates on the same clock edge as the triggering tick or write.
- Overflow sequence:
  - The 0xFF→0x00 increment happens at tick k.
  - The reload from TMA and the oIrq pulse happen at tick k+1.
  - oIrq is high for exactly one iClock cycle, coincident with the reload edge.
- Reset mid-operation clears the OVF/RELOAD state, and no interrupt pulse is emitted.
- Each channel is independent. Simultaneous overflows on several channels pulse their oIrq bits in the same cycle.

## Structure
- Shared package/header timer_defs:
  - register offsets (DIV/TIMA/TMA/TAC);
  - tap-bit constants per TAC[1:0];
  - channel FSM state encodings (RUN/OVF/RELOAD).
- Sub-module timer_channel:
  - holds TIMA/TMA/TAC, the FSM and edge detection;
  - takes current and next cnt tap inputs, tick and decoded write strobes;
  - instantiated N_CH times with a generate loop.
- The top level holds the system counter, address decode and read mux.

## Test plan
- Reset with CNT_INIT=0, TAC=0x05 (bit 3): after 4 ticks TIMA=1; after 8 ticks TIMA=2; oIrq stays 0.
- TMA=0xAB, TIMA=0xFF, TAC=0x05: the next falling edge makes TIMA=0x00. The following tick makes TIMA=0xAB with oIrq=1 for one cycle.
- Same setup, with TIMA written to 0x10 during OVF: TIMA=0x10, no reload, oIrq never asserts.
- TAC=0x04 (bit 9) with cnt bit 9 set, then write DIV: cnt=0, TIMA increments by 1 (spurious edge), oDiv=0.
- TAC=0x05 with cnt bit 3 set, then write TAC=0x01 (disable): TIMA increments by 1 from the enable falling edge.
- N_CH=2, channel 1 TAC=0x07 and channel 0 disabled: only oTima[15:8] advances, once every 64 ticks. A read of address 0x9 returns 0xFF.
